// File: rtl/game_tick_scheduler_if.sv
// Handshake bundle between the game tick scheduler and the game-logic blocks.
// The master drives the game event pulses; the slave returns the strobes, the phase and the speed level.
interface game_tick_scheduler_if;
    logic       start;
    logic       pause_toggle;
    logic       hit;
    logic       miss;
    logic       ms_tick;
    logic       ball_step;
    logic       paddle_step;
    logic [1:0] state;
    logic [3:0] level;

    modport master (
        output start, pause_toggle, hit, miss,
        input  ms_tick, ball_step, paddle_step, state, level
    );

    modport slave (
        input  start, pause_toggle, hit, miss,
        output ms_tick, ball_step, paddle_step, state, level
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Pong timing scheduler: base-tick prescaler, idle/serve/play/pause sequencing, ball and paddle step strobes.
// All outputs registered, one cycle after the internal tick or input pulse; no backpressure (pulses are always accepted).
module game_tick_scheduler #(
    parameter int PRESCALE       = 50000,
    parameter int BALL_BASE      = 20,
    parameter int BALL_MIN       = 4,
    parameter int LEVEL_STEP     = 2,
    parameter int HITS_PER_LEVEL = 4,
    parameter int PADDLE_DIV     = 5,
    parameter int SERVE_TICKS    = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    game_tick_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, PAUSED = 2'd3} state_t;

    localparam int PW = $clog2(PRESCALE + 1);
    localparam int SW = $clog2(SERVE_TICKS + 1);
    localparam int DW = $clog2(PADDLE_DIV + 1);
    localparam int HW = $clog2(HITS_PER_LEVEL + 1);

    state_t         state_q, state_d, saved_q, saved_d, base_nxt;
    logic [PW-1:0]  presc_q, presc_d;
    logic [SW-1:0]  serve_q, serve_d;
    logic [31:0]    ball_q, ball_d;
    logic [DW-1:0]  pad_q, pad_d;
    logic [HW-1:0]  hits_q, hits_d;
    logic [3:0]     level_q, level_d;
    logic           ms_tick_q, ms_tick_d;
    logic           ball_step_q, ball_step_d;
    logic           paddle_step_q, paddle_step_d;
    logic           tick, do_miss, do_pause, do_hit;
    logic signed [31:0] period_raw;
    logic [31:0]    period;

    always_comb begin
        tick       = (presc_q == PW'(PRESCALE - 1)) && (state_q != PAUSED);
        do_miss    = bus.miss && (state_q == PLAY);
        do_pause   = bus.pause_toggle && (state_q != IDLE) && !do_miss;
        do_hit     = bus.hit && (state_q == PLAY) && !do_miss && !do_pause;
        // Signed so that high levels drive the raw period negative and hit the clamp.
        period_raw = BALL_BASE - $signed({28'd0, level_q}) * LEVEL_STEP;
        period     = (period_raw < BALL_MIN) ? 32'(BALL_MIN) : $unsigned(period_raw);

        state_d       = state_q;
        saved_d       = saved_q;
        base_nxt      = state_q;
        serve_d       = serve_q;
        ball_d        = ball_q;
        pad_d         = pad_q;
        hits_d        = hits_q;
        level_d       = level_q;
        ms_tick_d     = tick;
        ball_step_d   = 1'b0;
        paddle_step_d = 1'b0;

        if (state_q == PAUSED)
            presc_d = presc_q;
        else if (presc_q == PW'(PRESCALE - 1))
            presc_d = '0;
        else
            presc_d = presc_q + PW'(1);

        if (state_q == IDLE)
            pad_d = '0;
        if (tick && (state_q == SERVE || state_q == PLAY)) begin
            if (pad_q == DW'(PADDLE_DIV - 1)) begin
                pad_d         = '0;
                paddle_step_d = 1'b1;
            end else begin
                pad_d = pad_q + DW'(1);
            end
        end

        // >= rather than == so a period shrinking mid-count still yields a step.
        if (tick && state_q == PLAY) begin
            if (ball_q >= period - 32'd1) begin
                ball_d      = '0;
                ball_step_d = 1'b1;
            end else begin
                ball_d = ball_q + 32'd1;
            end
        end

        if (tick && state_q == SERVE) begin
            if (serve_q == SW'(SERVE_TICKS - 1))
                base_nxt = PLAY;
            else
                serve_d = serve_q + SW'(1);
        end

        if (do_hit) begin
            if (hits_q == HW'(HITS_PER_LEVEL - 1)) begin
                hits_d = '0;
                if (level_q != 4'd15)
                    level_d = level_q + 4'd1;
            end else begin
                hits_d = hits_q + HW'(1);
            end
        end

        if (state_q == IDLE && bus.start)
            base_nxt = SERVE;
        if (do_miss)
            base_nxt = SERVE;

        if (base_nxt == SERVE && state_q != SERVE) begin
            serve_d = '0;
            ball_d  = '0;
            hits_d  = '0;
            level_d = '0;
        end

        // A pause landing on the serve-completing tick resumes straight into PLAY.
        if (state_q == PAUSED) begin
            if (do_pause)
                state_d = saved_q;
        end else if (do_pause) begin
            state_d = PAUSED;
            saved_d = base_nxt;
        end else begin
            state_d = base_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            saved_q       <= IDLE;
            presc_q       <= '0;
            serve_q       <= '0;
            ball_q        <= '0;
            pad_q         <= '0;
            hits_q        <= '0;
            level_q       <= '0;
            ms_tick_q     <= 1'b0;
            ball_step_q   <= 1'b0;
            paddle_step_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            presc_q       <= presc_d;
            serve_q       <= serve_d;
            ball_q        <= ball_d;
            pad_q         <= pad_d;
            hits_q        <= hits_d;
            level_q       <= level_d;
            ms_tick_q     <= ms_tick_d;
            ball_step_q   <= ball_step_d;
            paddle_step_q <= paddle_step_d;
        end
    end

    assign bus.ms_tick     = ms_tick_q;
    assign bus.ball_step   = ball_step_q;
    assign bus.paddle_step = paddle_step_q;
    assign bus.state       = state_q;
    assign bus.level       = level_q;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with small parameters; strobe times are predicted by hand
// and queued ahead of time, then matched cycle-by-cycle against the DUT strobes.
module tb_game_tick_scheduler;
    logic clk = 1'b0;
    logic reset;

    game_tick_scheduler_if bus ();

    game_tick_scheduler #(
        .PRESCALE(4), .BALL_BASE(6), .BALL_MIN(2), .LEVEL_STEP(2),
        .HITS_PER_LEVEL(2), .PADDLE_DIV(3), .SERVE_TICKS(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ms_q[$];
    int ball_q[$];
    int pad_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int first, input int period, input int last);
        for (int t = first; t <= last; t += period) begin
            case (ch)
                0:       ms_q.push_back(t);
                1:       ball_q.push_back(t);
                default: pad_q.push_back(t);
            endcase
        end
    endtask

    // One clock: sample after the falling edge and match strobes against the queued expectations.
    task automatic step();
        logic e;
        @(negedge clk);
        cyc++;
        e = (ms_q.size() > 0 && ms_q[0] == cyc);
        if (bus.ms_tick || e) check("ms_tick", 32'(bus.ms_tick), 32'(e));
        if (e) void'(ms_q.pop_front());
        e = (ball_q.size() > 0 && ball_q[0] == cyc);
        if (bus.ball_step || e) check("ball_step", 32'(bus.ball_step), 32'(e));
        if (e) void'(ball_q.pop_front());
        if (bus.ball_step) check("ball_on_ms", 32'(bus.ms_tick), 32'd1);
        e = (pad_q.size() > 0 && pad_q[0] == cyc);
        if (bus.paddle_step || e) check("paddle_step", 32'(bus.paddle_step), 32'(e));
        if (e) void'(pad_q.pop_front());
        if (bus.paddle_step) check("paddle_on_ms", 32'(bus.ms_tick), 32'd1);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic hits(input int n);
        bus.hit = 1'b1;
        repeat (n) step();
        bus.hit = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.pause_toggle = 1'b0;
        bus.hit = 1'b0;
        bus.miss = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ms_tick", 32'(bus.ms_tick), 0);
        check("rst_ball_step", 32'(bus.ball_step), 0);
        check("rst_paddle_step", 32'(bus.paddle_step), 0);
        check("rst_state", 32'(bus.state), 0);
        check("rst_level", 32'(bus.level), 0);

        reset = 1'b1;
        cyc = 0;
        push(0, 4, 4, 56);
        push(2, 16, 12, 52);
        push(1, 48, 24, 48);
        run_to(5);
        check("idle_state", 32'(bus.state), 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_serve", 32'(bus.state), 1);
        run_to(23);
        check("serve_before_5th", 32'(bus.state), 1);
        step();
        check("play_at_5th_tick", 32'(bus.state), 2);

        run_to(57);
        bus.pause_toggle = 1'b1;
        step();
        bus.pause_toggle = 1'b0;
        check("paused", 32'(bus.state), 3);
        run_to(167);
        check("still_paused", 32'(bus.state), 3);
        push(0, 170, 4, 314);
        push(2, 174, 12, 306);
        push(1, 182, 24, 182);
        bus.pause_toggle = 1'b1;
        step();
        bus.pause_toggle = 1'b0;
        check("resumed", 32'(bus.state), 2);

        run_to(183);
        hits(2);
        push(1, 198, 16, 198);
        run_to(186);
        check("level1", 32'(bus.level), 1);
        run_to(199);
        hits(2);
        push(1, 206, 8, 206);
        check("level2", 32'(bus.level), 2);
        run_to(207);
        hits(2);
        push(1, 214, 8, 246);
        check("level3", 32'(bus.level), 3);
        run_to(215);
        hits(24);
        check("level15", 32'(bus.level), 15);
        run_to(241);
        hits(2);
        check("level_sat", 32'(bus.level), 15);

        run_to(247);
        bus.miss = 1'b1;
        step();
        bus.miss = 1'b0;
        check("miss_serve", 32'(bus.state), 1);
        check("miss_level0", 32'(bus.level), 0);
        run_to(265);
        check("serve2_hold", 32'(bus.state), 1);
        step();
        check("play2", 32'(bus.state), 2);
        hits(2);
        check("play2_level1", 32'(bus.level), 1);
        run_to(270);
        hits(2);
        check("play2_level2", 32'(bus.level), 2);
        bus.hit = 1'b1;
        bus.miss = 1'b1;
        step();
        bus.hit = 1'b0;
        bus.miss = 1'b0;
        check("hitmiss_state", 32'(bus.state), 1);
        check("hitmiss_level", 32'(bus.level), 0);
        push(1, 314, 24, 314);
        run_to(289);
        check("serve3_hold", 32'(bus.state), 1);
        step();
        check("play3", 32'(bus.state), 2);
        run_to(291);
        hits(1);
        check("hitcnt_cleared", 32'(bus.level), 0);

        run_to(317);
        check("ms_pending", 32'(ms_q.size()), 0);
        check("ball_pending", 32'(ball_q.size()), 0);
        check("paddle_pending", 32'(pad_q.size()), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_ms_tick", 32'(bus.ms_tick), 0);
        check("midrst_paddle", 32'(bus.paddle_step), 0);
        check("midrst_ball", 32'(bus.ball_step), 0);
        check("midrst_state", 32'(bus.state), 0);
        check("midrst_level", 32'(bus.level), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        push(0, 4, 4, 8);
        step();
        check("post_rst_state", 32'(bus.state), 0);
        run_to(10);
        check("ms_left", 32'(ms_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Central timing scheduler for the Pong game. It divides the 50 MHz system clock into a 1 kHz base tick and sequences the game through idle, serve, play and pause phases. It issues single-cycle step strobes to the ball and paddle movement logic, and shortens the ball step period as the rally's hit count grows. It sits between the board clock and the game-logic blocks, replacing per-block free-running dividers.

## Interface
- PRESCALE, 50000: clk cycles per base tick (1 kHz at 50 MHz)
- BALL_BASE, 20: base ticks per ball step at level 0
- BALL_MIN, 4: minimum base ticks per ball step (clamp)
- LEVEL_STEP, 2: ball period reduction per level, in base ticks
- HITS_PER_LEVEL, 4: paddle hits needed to advance one level
- PADDLE_DIV, 5: base ticks per paddle step
- SERVE_TICKS, 1000: base ticks of serve delay before play
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse; begins a game from IDLE
- pause_toggle  in  1  one-cycle pulse; enters or leaves PAUSED
- hit  in  1  one-cycle pulse; ball struck a paddle
- miss  in  1  one-cycle pulse; point scored, ball lost
- ms_tick  out  1  one-cycle base tick strobe
- ball_step  out  1  one-cycle ball move strobe
- paddle_step  out  1  one-cycle paddle move strobe
- state  out  2  0=IDLE, 1=SERVE, 2=PLAY, 3=PAUSED
- level  out  4  current speed level, saturates at 15

## Operation
- The prescaler counts 0..PRESCALE-1 and wraps. The internal tick is true when prescaler==PRESCALE-1 and state!=PAUSED. In PAUSED the prescaler holds its value.
- FSM transitions:
  - IDLE: start -> SERVE.
  - SERVE: the serve counter increments on each tick; a tick with serve counter==SERVE_TICKS-1 -> PLAY.
  - PLAY: miss -> SERVE.
  - PLAY or SERVE: pause_toggle -> PAUSED; the origin state is saved.
  - PAUSED: pause_toggle -> saved state.
- start is ignored outside IDLE. hit and miss are ignored outside PLAY. pause_toggle is ignored in IDLE.
- Priority within one cycle: miss > pause_toggle > hit.
- Entering SERVE clears the serve counter, ball counter and hit counter. Entering SERVE from miss also clears level to 0. The first SERVE after start also has level 0.
- Ball period = max(BALL_BASE - level*LEVEL_STEP, BALL_MIN). Evaluate it in signed arithmetic wide enough that a negative result clamps to BALL_MIN.
- Ball counter runs only in PLAY and increments per tick. On a tick with ball counter >= period-1, the counter clears and ball_step fires. Using >= guarantees a level change mid-count never skips a step.
- Paddle counter runs in SERVE and PLAY. On a tick with counter==PADDLE_DIV-1, the counter clears and paddle_step fires. The counter is cleared in IDLE.
- A hit in PLAY increments the hit counter. When the hit counter reaches HITS_PER_LEVEL, the hit counter clears and level increments, saturating at 15.
- PAUSED freezes the prescaler, serve, ball, paddle and hit counters, and level. Resuming continues from the frozen values.

## Timing
- Reset values: ms_tick=0, ball_step=0, paddle_step=0, state=0 (IDLE), level=0. All counters are 0.
- All outputs are registered. Each strobe is high for exactly one clk cycle, in the cycle after the internal tick.
- ball_step and paddle_step always coincide with an ms_tick.
- Inputs are sampled on the rising edge. state updates one cycle after the input pulse.
- ms_tick period is exactly PRESCALE clk cycles. The first ms_tick follows PRESCALE rising edges after reset release.
- In PLAY at a constant level, ball_step period is period*PRESCALE cycles.
- Reset asserted mid-operation forces all reset values immediately and asynchronously. Strobes in flight are dropped.

## Test plan
Benches use PRESCALE=4, BALL_BASE=6, BALL_MIN=2, LEVEL_STEP=2, HITS_PER_LEVEL=2, PADDLE_DIV=3, SERVE_TICKS=5.
- Release reset, no inputs -> state=0; ms_tick every 4 cycles; no ball_step or paddle_step.
- start pulse -> state=1 next cycle; paddle_step every 12 cycles; no ball_step; state=2 on the 5th tick after entry.
- In PLAY at level 0 -> ball_step every 24 cycles, coincident with ms_tick.
- 2 hits -> level=1, ball_step every 16 cycles. 2 more -> level=2, every 8. 2 more -> level=3, every 8 (clamped at BALL_MIN). 24 more hits -> level holds at 15.
- hit and miss in the same cycle at level 2 -> state=1, level=0, hit counter 0.
- pause_toggle in PLAY -> state=3, no strobes for 100 cycles. pause_toggle again -> state=2; the first ball_step arrives exactly the remaining frozen count later.
- Reset pulse mid-PLAY -> all outputs 0 the same cycle; state=0 after release.
